riscv_prefetch: RTL and testbench
=================================

RISCV_PREFETCH -- requirements
Module: riscv_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_boot_addr  input  32  first fetch address after reset.
REQ-005 SHALL have port i_redirect  input  1  branch/jump redirect pulse from pipeline.
REQ-006 SHALL have port i_redirect_target  input  32  new fetch PC.
REQ-007 SHALL have port i_stall  input  1  consumer (IF stage) not accepting head entry.
REQ-008 SHALL have port o_valid  output  1  head entry valid.
REQ-009 SHALL have port o_pc  output  32  head entry PC.
REQ-010 SHALL have port o_instr  output  32  head entry instruction.
REQ-011 SHALL have port o_bus_req  output  1  instruction read request.
REQ-012 SHALL have port o_bus_addr  output  32  request word address.
REQ-013 SHALL have port i_bus_gnt  input  1  request accepted this cycle.
REQ-014 SHALL have port i_bus_rvalid  input  1  read data valid, in request order.
REQ-015 SHALL have port i_bus_rdata  input  32  read data.

Function
REQ-016 SHALL implement FSM BOOT, RUN, DISCARD; BOOT lasts one cycle after reset release, then RUN with fetch PC = i_boot_addr.
REQ-017 SHALL assert o_bus_req in RUN when (queue count + outstanding) < DEPTH; hold o_bus_addr stable while o_bus_req && !i_bus_gnt.
REQ-018 SHALL on grant increment outstanding and advance fetch PC by 4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
REQ-019 SHALL on i_bus_rvalid (not discarded) push {pc, rdata} to queue tail; pc is the address of the matching grant.
REQ-020 SHALL pop head when o_valid && !i_stall; push and pop in the same cycle leave count unchanged, legal when full.
REQ-021 SHALL drive o_instr = 32'h00000013 (NOP) and o_pc = 0 when queue empty; o_valid = (count != 0).
REQ-022 SHALL on i_redirect flush queue same edge, load fetch PC = {i_redirect_target[31:2], 2'b00}, deassert o_bus_req next cycle; redirect overrides push, pop and grant in that cycle.
REQ-023 SHALL enter DISCARD after redirect when outstanding (incl. a grant in the redirect cycle) > 0, dropping that many responses, then RUN; else go directly to RUN.
REQ-024 SHALL honour a redirect arriving in DISCARD by reloading target and keeping discard count.
REQ-025 SHALL never exceed DEPTH outstanding+queued entries; response with outstanding == 0 is ignored.

Reset
REQ-026 SHALL on rst_n low asynchronously clear queue, outstanding and discard counters, state = BOOT, o_valid = 0, o_bus_req = 0, o_bus_addr = 0, o_pc = 0, o_instr = NOP.
REQ-027 SHALL abandon in-flight requests on reset mid-operation; responses arriving in BOOT are ignored.

Configuration
REQ-028 SHALL, with RISCV_PREFETCH_BYPASS_EN defined, present a non-discarded response combinationally on o_valid/o_pc/o_instr when queue empty, not writing it if popped that cycle (0-cycle latency).
REQ-029 SHALL, without RISCV_PREFETCH_BYPASS_EN, route every response through the queue (head visible one cycle after rvalid).

Structure
REQ-030 SHALL place NOP constant, FSM state enum and {pc, instr} entry struct in shared package riscv_pkg.
REQ-031 SHALL instantiate one sub-module riscv_fifo (synchronous FIFO, flush input, async active-low reset).

Verification
REQ-032 SHALL cover boot: i_boot_addr=0x1000, gnt=1, rvalid 1 cycle later -> o_bus_addr 0x1000,0x1004,...; o_pc 0x1000 first with o_valid=1.
REQ-033 SHALL cover back-pressure: i_stall=1 for 10 cycles, DEPTH=4 -> o_bus_req drops after 4 grants, head o_pc unchanged, no loss after release.
REQ-034 SHALL cover redirect with 2 outstanding: i_redirect, target 0x2002 -> state DISCARD, 2 responses dropped, next o_bus_addr 0x2000, next o_pc 0x2000.
REQ-035 SHALL cover simultaneous redirect+rvalid+pop on full queue -> queue empty next cycle, o_valid=0, o_instr=0x00000013.
REQ-036 SHALL cover wrap: fetch PC 0xFFFFFFFC granted -> next o_bus_addr 0x00000000.
REQ-037 SHALL cover async reset mid-fetch with 3 outstanding -> outputs at reset values immediately, restart at i_boot_addr, stale responses ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the instruction prefetch buffer: NOP encoding, FSM states
// and the {pc, instr} queue entry.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DISCARD
  } pfState_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pfEntry_t;

endpackage

// File: rtl/riscv_fifo.sv
// Synchronous FIFO of prefetch entries with single-cycle flush.
// Push while full is legal only together with a pop.
module riscv_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  pfEntry_t      wdata,
  output pfEntry_t      rdata,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wrPtr, rdPtr;
  pfEntry_t      mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= wdata;
  end

  assign rdata = mem[rdPtr];

endmodule

// File: rtl/riscv_prefetch.sv
// Instruction prefetch buffer: issues sequential word reads, queues responses,
// flushes on redirect. Define RISCV_PREFETCH_BYPASS_EN for 0-cycle response bypass.
module riscv_prefetch
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_boot_addr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  pfState_e      state, stateNext;
  logic [31:0]   fetchPc, rspPc, target;
  logic [CW-1:0] outstanding, outstandingNext, discardCnt, discardNext, qCount;
  logic          reqBlock, gnt, rspAccept, pushCand, push, pop, qEmpty, bypass;
  pfEntry_t      head, wEntry;

  assign target = {i_redirect_target[31:2], 2'b00};
  assign qEmpty = (qCount == '0);

  // reqBlock holds the request low for the cycle right after a redirect.
  assign o_bus_req  = (state == RUN) && !reqBlock &&
                      (({1'b0, qCount} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign o_bus_addr = fetchPc;
  assign gnt        = o_bus_req && i_bus_gnt;

  assign rspAccept       = i_bus_rvalid && (state != BOOT) && (outstanding != '0);
  assign pushCand        = rspAccept && (discardCnt == '0) && !i_redirect;
  assign outstandingNext = outstanding + CW'(gnt) - CW'(rspAccept);

  always_comb begin
    discardNext = discardCnt;
    if (i_redirect && state != BOOT) discardNext = outstandingNext;
    else if (rspAccept && discardCnt != '0) discardNext = discardCnt - CW'(1);
  end

  always_comb begin
    stateNext = state;
    case (state)
      BOOT:         stateNext = RUN;
      RUN, DISCARD: stateNext = (discardNext != '0) ? DISCARD : RUN;
      default:      stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetchPc     <= '0;
      rspPc       <= '0;
      outstanding <= '0;
      discardCnt  <= '0;
      reqBlock    <= 1'b0;
    end else begin
      state       <= stateNext;
      outstanding <= outstandingNext;
      discardCnt  <= discardNext;
      reqBlock    <= i_redirect && (state != BOOT);
      if (state == BOOT) begin
        fetchPc <= i_boot_addr;
        rspPc   <= i_boot_addr;
      end else if (i_redirect) begin
        fetchPc <= target;
        rspPc   <= target;
      end else begin
        if (gnt)      fetchPc <= fetchPc + 32'd4;
        if (pushCand) rspPc   <= rspPc + 32'd4;
      end
    end
  end

`ifdef RISCV_PREFETCH_BYPASS_EN
  assign bypass = qEmpty && pushCand;
  assign push   = pushCand && !(bypass && !i_stall);
`else
  assign bypass = 1'b0;
  assign push   = pushCand;
`endif

  assign pop    = !qEmpty && !i_stall && !i_redirect;
  assign wEntry = {rspPc, i_bus_rdata};

  riscv_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wEntry),
    .rdata (head),
    .count (qCount)
  );

  always_comb begin
    o_valid = 1'b0;
    o_pc    = '0;
    o_instr = NOP;
    if (!qEmpty) begin
      o_valid = 1'b1;
      o_pc    = head.pc;
      o_instr = head.instr;
    end else if (bypass) begin
      o_valid = 1'b1;
      o_pc    = rspPc;
      o_instr = i_bus_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_prefetch.sv
// Directed bench for riscv_prefetch: boot, back-pressure, redirect/discard,
// full-queue redirect, address wrap and reset mid-fetch.
module tb_riscv_prefetch;
  import riscv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] i_boot_addr = '0, i_redirect_target = '0, i_bus_rdata = '0;
  logic        i_redirect = 1'b0, i_stall = 1'b0, i_bus_gnt = 1'b0, i_bus_rvalid = 1'b0;
  logic        o_valid, o_bus_req;
  logic [31:0] o_pc, o_instr, o_bus_addr;

  int checks = 0, errors = 0;

  // bus model controls
  logic        gntEn = 1'b0, rspHold = 1'b0, forceRv = 1'b0;
  logic [31:0] rspQ [$];

  riscv_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_boot_addr(i_boot_addr), .i_redirect(i_redirect),
    .i_redirect_target(i_redirect_target), .i_stall(i_stall), .o_valid(o_valid),
    .o_pc(o_pc), .o_instr(o_instr), .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  // Memory image: word at address a reads as a ^ 0xC0DE0000.
  always @(negedge clk) begin
    if (forceRv) begin
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = 32'hBAD0_BAD0;
    end else if (!rspHold && rspQ.size() > 0) begin
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = rspQ.pop_front() ^ 32'hC0DE_0000;
    end else begin
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = '0;
    end
    i_bus_gnt = gntEn;
    if (rst_n && o_bus_req && gntEn) rspQ.push_back(o_bus_addr);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_bus_req); end
    checks++; if (o_bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", o_bus_addr); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", o_pc); end
    checks++; if (o_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", o_instr); end
    step(); step();
  endtask

  task automatic test_boot();
    i_boot_addr = 32'h1000; gntEn = 1'b1; i_stall = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (o_bus_req !== 1'b1) begin errors++; $display("FAIL boot_req: got %b want 1", o_bus_req); end
    checks++; if (o_bus_addr !== 32'h1000) begin errors++; $display("FAIL boot_addr0: got %h want 00001000", o_bus_addr); end
    step();
    checks++; if (o_bus_addr !== 32'h1004) begin errors++; $display("FAIL boot_addr1: got %h want 00001004", o_bus_addr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL boot_early_valid: got %b want 0", o_valid); end
    step();
    checks++; if (o_bus_addr !== 32'h1008) begin errors++; $display("FAIL boot_addr2: got %h want 00001008", o_bus_addr); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL boot_valid: got %b want 1", o_valid); end
    checks++; if (o_pc !== 32'h1000) begin errors++; $display("FAIL boot_pc: got %h want 00001000", o_pc); end
    checks++; if (o_instr !== 32'hC0DE_1000) begin errors++; $display("FAIL boot_instr: got %h want c0de1000", o_instr); end
    step();
    checks++; if (o_pc !== 32'h1004) begin errors++; $display("FAIL boot_pc1: got %h want 00001004", o_pc); end
  endtask

  task automatic test_back_pressure();
    i_stall = 1'b1;
    repeat (10) step();
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0", o_bus_req); end
    checks++; if (o_pc !== 32'h1004) begin errors++; $display("FAIL bp_head: got %h want 00001004", o_pc); end
    checks++; if (dut.qCount !== 3'd4) begin errors++; $display("FAIL bp_full: got %0d want 4", dut.qCount); end
    i_stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (o_pc !== 32'h1004 + 32'(4*i) || o_instr !== 32'hC0DE_1004 + 32'(4*i))
        begin errors++; $display("FAIL bp_drain%0d: got %h/%h want %h", i, o_pc, o_instr, 32'h1004 + 32'(4*i)); end
    end
  endtask

  task automatic test_redirect();
    gntEn = 1'b0;
    repeat (6) step();
    rspHold = 1'b1; gntEn = 1'b1;
    step(); step();
    gntEn = 1'b0;
    i_redirect = 1'b1; i_redirect_target = 32'h2002;
    step();
    i_redirect = 1'b0;
    checks++; if (dut.state !== DISCARD) begin errors++; $display("FAIL redir_state: got %0d want DISCARD", dut.state); end
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b want 0", o_bus_req); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", o_valid); end
    rspHold = 1'b0; gntEn = 1'b1;
    step();
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL redir_disc_req: got %b want 0", o_bus_req); end
    step();
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h2000) begin errors++; $display("FAIL redir_addr: got %b/%h want 1/00002000", o_bus_req, o_bus_addr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped: got %b want 0", o_valid); end
    step(); step();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h2000) begin errors++; $display("FAIL redir_pc: got %b/%h want 1/00002000", o_valid, o_pc); end
    checks++; if (o_instr !== 32'hC0DE_2000) begin errors++; $display("FAIL redir_instr: got %h want c0de2000", o_instr); end
  endtask

  task automatic test_full_redirect();
    i_stall = 1'b1;
    repeat (8) step();
    checks++; if (dut.qCount !== 3'd4 || o_bus_req !== 1'b0) begin errors++; $display("FAIL full_pre: got %0d/%b want 4/0", dut.qCount, o_bus_req); end
    i_stall = 1'b0; i_redirect = 1'b1; i_redirect_target = 32'h4000; forceRv = 1'b1; gntEn = 1'b0;
    step();
    i_redirect = 1'b0; forceRv = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_valid: got %b want 0", o_valid); end
    checks++; if (o_instr !== 32'h13) begin errors++; $display("FAIL full_instr: got %h want 00000013", o_instr); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL full_pc: got %h want 00000000", o_pc); end
  endtask

  task automatic test_wrap();
    step();
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h4000) begin errors++; $display("FAIL hold_addr0: got %b/%h want 1/00004000", o_bus_req, o_bus_addr); end
    step();
    checks++; if (o_bus_addr !== 32'h4000) begin errors++; $display("FAIL hold_addr1: got %h want 00004000", o_bus_addr); end
    i_redirect = 1'b1; i_redirect_target = 32'hFFFF_FFF8; gntEn = 1'b1;
    step();
    i_redirect = 1'b0;
    checks++; if (dut.state !== DISCARD) begin errors++; $display("FAIL wrap_disc: got %0d want DISCARD", dut.state); end
    step();
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0: got %b/%h want 1/fffffff8", o_bus_req, o_bus_addr); end
    step();
    checks++; if (o_bus_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1: got %h want fffffffc", o_bus_addr); end
    step();
    checks++; if (o_bus_addr !== 32'h0) begin errors++; $display("FAIL wrap_a2: got %h want 00000000", o_bus_addr); end
    checks++; if (o_pc !== 32'hFFFF_FFF8 || o_instr !== 32'h3F21_FFF8) begin errors++; $display("FAIL wrap_h0: got %h/%h want fffffff8/3f21fff8", o_pc, o_instr); end
    step();
    checks++; if (o_pc !== 32'hFFFF_FFFC || o_instr !== 32'h3F21_FFFC) begin errors++; $display("FAIL wrap_h1: got %h/%h want fffffffc/3f21fffc", o_pc, o_instr); end
    step();
    checks++; if (o_pc !== 32'h0 || o_instr !== 32'hC0DE_0000) begin errors++; $display("FAIL wrap_h2: got %h/%h want 00000000/c0de0000", o_pc, o_instr); end
  endtask

  task automatic test_reset_mid();
    gntEn = 1'b0;
    repeat (6) step();
    rspHold = 1'b1; gntEn = 1'b1;
    step(); step(); step();
    gntEn = 1'b0;
    checks++; if (dut.outstanding !== 3'd3) begin errors++; $display("FAIL rst_pre_out: got %0d want 3", dut.outstanding); end
    i_boot_addr = 32'h8000;
    rst_n = 1'b0;
    #1;
    checks++; if (o_bus_req !== 1'b0 || o_bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus: got %b/%h want 0/00000000", o_bus_req, o_bus_addr); end
    checks++; if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h13) begin errors++; $display("FAIL rst_out: got %b/%h/%h want 0/00000000/00000013", o_valid, o_pc, o_instr); end
    rspHold = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h8000) begin errors++; $display("FAIL rst_boot: got %b/%h want 1/00008000", o_bus_req, o_bus_addr); end
    gntEn = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_stale: got %b want 0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8000 || o_instr !== 32'hC0DE_8000) begin errors++; $display("FAIL rst_first: got %b/%h/%h want 1/00008000/c0de8000", o_valid, o_pc, o_instr); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_back_pressure();
    test_redirect();
    test_full_redirect();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
